// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner.
// Column rotation, 2-flop row sync, press/release debounce, hex key code.
module keypad_scanner #(
  parameter int SCAN_THRESHOLD  = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_THRESHOLD);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_THRESHOLD - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    cols_q, cols_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic [3:0]    rs1_q, rs_q;

  logic strobe;
  logic deb_last;
  logic row_low;
  logic any_low;

  function automatic logic [1:0] prio(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd3;
    priority case (1'b1)
      !r[0]:   idx = 2'd0;
      !r[1]:   idx = 2'd1;
      !r[2]:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] keymap(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    k = 4'h0;
    unique case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      4'b11_11: k = 4'hD;
      default:  k = 4'h0;
    endcase
    return k;
  endfunction

  assign strobe   = (scan_q == SCAN_LAST);
  assign deb_last = (deb_q == DEB_LAST);
  assign row_low  = ~rs_q[row_q];
  assign any_low  = (rs_q != 4'hF);

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    deb_d   = deb_q;
    col_d   = col_q;
    row_d   = row_q;
    cols_d  = cols_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    unique case (state_q)
      SCAN: begin
        if (strobe) begin
          scan_d = '0;
          if (!any_low) begin
            col_d  = col_q + 2'd1;
            cols_d = {cols_q[2:0], cols_q[3]};
          end else begin
            row_d   = prio(rs_q);
            deb_d   = '0;
            state_d = DEBOUNCE;
          end
        end else begin
          scan_d = scan_q + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_low) begin
          if (deb_last) begin
            key_d   = keymap(row_q, col_q);
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = HELD;
          end else begin
            deb_d = deb_q + DW'(1);
          end
        end else begin
          scan_d  = '0;
          state_d = SCAN;
        end
      end
      HELD: begin
        if (!row_low) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // A low blip while releasing means the key is still down.
        if (!row_low) begin
          if (deb_last) begin
            held_d  = 1'b0;
            scan_d  = '0;
            state_d = SCAN;
          end else begin
            deb_d = deb_q + DW'(1);
          end
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SCAN;
      scan_q  <= '0;
      deb_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cols_q  <= 4'b1110;
      key_q   <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      rs1_q   <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      deb_q   <= deb_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cols_q  <= cols_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      rs1_q   <= rows;
      rs_q    <= rs1_q;
    end
  end

  assign cols      = cols_q;
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner.
// SCAN_THRESHOLD=4, DEBOUNCE_CYCLES=8.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  int errors = 0;
  int checks = 0;

  logic [3:0] ctab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scanner #(
    .SCAN_THRESHOLD (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait for cols to newly take value v, so the scan count is 0.
  task automatic wait_fresh(input logic [3:0] v);
    int n;
    n = 0;
    while (cols === v && n < 40) begin
      tick();
      n++;
    end
    while (cols !== v && n < 40) begin
      tick();
      n++;
    end
    chk("wait_cols", cols, v);
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    while (key_held !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_release", {3'b0, key_held}, 4'h0);
  endtask

  initial begin
    reset = 1'b0;
    rows  = 4'hF;
    ticks(3);
    chk("rst_cols", cols, 4'b1110);
    chk("rst_key", key, 4'h0);
    chk("rst_valid", {3'b0, key_valid}, 4'h0);
    chk("rst_held", {3'b0, key_held}, 4'h0);
    reset = 1'b1;

    // 1: idle rotation, 4 cycles per column
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("idle_cols", cols, ctab[(i / 4) % 4]);
      chk("idle_valid", {3'b0, key_valid}, 4'h0);
    end
    chk("idle_key", key, 4'h0);

    // 2: press row 2 at column 1 -> key 8
    wait_fresh(4'b1101);
    rows = 4'b1011;
    ticks(4);
    chk("s2_capture_cols", cols, 4'b1101);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("s2_nopulse", {3'b0, key_valid}, 4'h0);
    end
    tick();
    chk("s2_valid", {3'b0, key_valid}, 4'h1);
    chk("s2_key", key, 4'h8);
    chk("s2_held", {3'b0, key_held}, 4'h1);
    tick();
    chk("s2_valid_once", {3'b0, key_valid}, 4'h0);
    chk("s2_held2", {3'b0, key_held}, 4'h1);
    chk("s2_cols_frozen", cols, 4'b1101);

    // 3: release, held falls, scan resumes, press again
    rows = 4'hF;
    ticks(10);
    chk("s3_held_still", {3'b0, key_held}, 4'h1);
    tick();
    chk("s3_held_fall", {3'b0, key_held}, 4'h0);
    ticks(3);
    chk("s3_cols_hold", cols, 4'b1101);
    tick();
    chk("s3_cols_adv", cols, 4'b1011);
    wait_fresh(4'b1101);
    rows = 4'b1011;
    ticks(11);
    chk("s3_nopulse", {3'b0, key_valid}, 4'h0);
    tick();
    chk("s3_valid2", {3'b0, key_valid}, 4'h1);
    chk("s3_key2", key, 4'h8);
    rows = 4'hF;
    wait_release();

    // 4: bounce at column 0, then stable press -> key 1
    wait_fresh(4'b1110);
    rows = 4'b1110;
    ticks(3);
    rows = 4'hF;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("s4_bounce_valid", {3'b0, key_valid}, 4'h0);
    end
    chk("s4_key_kept", key, 4'h8);
    chk("s4_held", {3'b0, key_held}, 4'h0);
    wait_fresh(4'b1110);
    rows = 4'b1110;
    ticks(12);
    chk("s4_valid", {3'b0, key_valid}, 4'h1);
    chk("s4_key", key, 4'h1);
    rows = 4'hF;
    wait_release();

    // 5: rows 0 and 3 at column 2 -> key 3; extra key ignored
    wait_fresh(4'b1011);
    rows = 4'b0110;
    ticks(12);
    chk("s5_valid", {3'b0, key_valid}, 4'h1);
    chk("s5_key", key, 4'h3);
    rows = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("s5_no_new", {3'b0, key_valid}, 4'h0);
    end
    chk("s5_held", {3'b0, key_held}, 4'h1);
    chk("s5_cols", cols, 4'b1011);
    chk("s5_key_kept", key, 4'h3);
    rows = 4'hF;
    wait_release();

    // 6a: reset during DEBOUNCE
    wait_fresh(4'b0111);
    rows = 4'b1110;
    ticks(6);
    chk("s6_deb_cols", cols, 4'b0111);
    reset = 1'b0;
    tick();
    chk("s6a_cols", cols, 4'b1110);
    chk("s6a_key", key, 4'h0);
    chk("s6a_held", {3'b0, key_held}, 4'h0);
    chk("s6a_valid", {3'b0, key_valid}, 4'h0);
    rows  = 4'hF;
    reset = 1'b1;

    // 6b: reset during HELD
    wait_fresh(4'b1110);
    rows = 4'b1110;
    ticks(12);
    chk("s6b_valid", {3'b0, key_valid}, 4'h1);
    chk("s6b_key", key, 4'h1);
    ticks(2);
    chk("s6b_held", {3'b0, key_held}, 4'h1);
    reset = 1'b0;
    tick();
    chk("s6b_cols", cols, 4'b1110);
    chk("s6b_key0", key, 4'h0);
    chk("s6b_held0", {3'b0, key_held}, 4'h0);
    chk("s6b_valid0", {3'b0, key_valid}, 4'h0);
    rows  = 4'hF;
    reset = 1'b1;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
